// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg                                                              |
// | Shared constants and helpers for the single- and dual-clock FIFOs.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int width, input int depth,
                                     input int af, input int ae);
        return (width >= 1) && (depth >= 2) && is_pow2(depth) &&
               (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_flags_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_flags_if                                                    |
// | Producer/consumer bus of the single-clock flagged FIFO.               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface sync_fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int c_CW = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] dat_i;
    logic             wen;
    logic             ren;
    logic             clr_err;
    logic [WIDTH-1:0] dat_o;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [c_CW-1:0]  count;
    logic             overflow;
    logic             underflow;

    modport master (
        output dat_i, wen, ren, clr_err,
        input  dat_o, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  dat_i, wen, ren, clr_err,
        output dat_o, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem                                                              |
// | DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset.|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int c_AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [c_AW-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [c_AW-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_flags                                                       |
// | Single-clock FIFO with occupancy count, almost flags, sticky errors   |
// | and selectable standard / first-word-fall-through read mode.          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = FWFT_OFF,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic               clk,
    input  logic               rst_ni,
    sync_fifo_flags_if.slave   bus
);

    localparam int c_AW = clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    if (!params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
        $error("sync_fifo_flags: illegal WIDTH/DEPTH/AF_THRESH/AE_THRESH");
    end

    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             r_overflow;
    logic             r_underflow;
    logic [c_CW-1:0]  w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_we;
    logic             w_re;
    logic [WIDTH-1:0] w_rdata;

    // Flags decode only from registered pointers, never from wen/ren.
    assign w_count = r_wptr - r_rptr;
    assign w_full  = (w_count == c_CW'(DEPTH));
    assign w_empty = (w_count == '0);
    assign w_we    = bus.wen && !w_full;
    assign w_re    = bus.ren && !w_empty;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_we) begin
                r_wptr <= r_wptr + c_CW'(1);
            end
            if (w_re) begin
                r_rptr <= r_rptr + c_CW'(1);
            end
            r_overflow  <= (bus.wen && w_full)  || (r_overflow  && !bus.clr_err);
            r_underflow <= (bus.ren && w_empty) || (r_underflow && !bus.clr_err);
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wptr[c_AW-1:0]),
        .wdata (bus.dat_i),
        .raddr (r_rptr[c_AW-1:0]),
        .rdata (w_rdata)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        assign bus.dat_o = w_rdata;
    end else begin : g_std
        logic [WIDTH-1:0] r_dat;

        always_ff @(posedge clk) begin
            if (!rst_ni) begin
                r_dat <= '0;
            end else if (w_re) begin
                r_dat <= w_rdata;
            end
        end

        assign bus.dat_o = r_dat;
    end

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (w_count >= c_CW'(AF_THRESH));
    assign bus.almost_empty = (w_count <= c_CW'(AE_THRESH));
    assign bus.count        = w_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_fifo_flags                                                    |
// | Directed bench for sync_fifo_flags in standard and FWFT modes.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sync_fifo_flags;

    logic clk;
    logic rst_ni;
    int   n_checks;
    int   n_pass;

    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(4)) bus_s ();
    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(4)) bus_f ();

    sync_fifo_flags #(
        .WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(2), .AE_THRESH(1)
    ) u_std (
        .clk    (clk),
        .rst_ni (rst_ni),
        .bus    (bus_s)
    );

    sync_fifo_flags #(
        .WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(2), .AE_THRESH(1)
    ) u_fwft (
        .clk    (clk),
        .rst_ni (rst_ni),
        .bus    (bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_wr(input logic [7:0] d);
        bus_s.dat_i = d;
        bus_s.wen   = 1'b1;
        tick();
        bus_s.wen   = 1'b0;
    endtask

    task automatic s_rd();
        bus_s.ren = 1'b1;
        tick();
        bus_s.ren = 1'b0;
    endtask

    task automatic s_both(input logic [7:0] d);
        bus_s.dat_i = d;
        bus_s.wen   = 1'b1;
        bus_s.ren   = 1'b1;
        tick();
        bus_s.wen   = 1'b0;
        bus_s.ren   = 1'b0;
    endtask

    task automatic s_clr();
        bus_s.clr_err = 1'b1;
        tick();
        bus_s.clr_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_ni   = 1'b0;
        bus_s.dat_i = '0; bus_s.wen = 1'b0; bus_s.ren = 1'b0; bus_s.clr_err = 1'b0;
        bus_f.dat_i = '0; bus_f.wen = 1'b0; bus_f.ren = 1'b0; bus_f.clr_err = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;

        check("rst_count", 32'(bus_s.count), 0);
        check("rst_empty", 32'(bus_s.empty), 1);
        check("rst_full", 32'(bus_s.full), 0);
        check("rst_ae", 32'(bus_s.almost_empty), 1);
        check("rst_af", 32'(bus_s.almost_full), 0);
        check("rst_ovf", 32'(bus_s.overflow), 0);
        check("rst_unf", 32'(bus_s.underflow), 0);
        check("rst_dat", 32'(bus_s.dat_o), 0);

        // Fill and drain with threshold tracking
        s_wr(8'h11);
        check("fill1_count", 32'(bus_s.count), 1);
        check("fill1_af", 32'(bus_s.almost_full), 0);
        check("fill1_ae", 32'(bus_s.almost_empty), 1);
        s_wr(8'h22);
        check("fill2_count", 32'(bus_s.count), 2);
        check("fill2_af", 32'(bus_s.almost_full), 1);
        check("fill2_ae", 32'(bus_s.almost_empty), 0);
        s_wr(8'h33);
        check("fill3_count", 32'(bus_s.count), 3);
        check("fill3_full", 32'(bus_s.full), 0);
        s_wr(8'h44);
        check("fill4_count", 32'(bus_s.count), 4);
        check("fill4_full", 32'(bus_s.full), 1);
        s_rd(); check("drain1_dat", 32'(bus_s.dat_o), 32'h11);
        check("drain1_full", 32'(bus_s.full), 0);
        s_rd(); check("drain2_dat", 32'(bus_s.dat_o), 32'h22);
        s_rd(); check("drain3_dat", 32'(bus_s.dat_o), 32'h33);
        s_rd(); check("drain4_dat", 32'(bus_s.dat_o), 32'h44);
        check("drain_empty", 32'(bus_s.empty), 1);
        check("drain_count", 32'(bus_s.count), 0);

        // Overflow: dropped write, sticky flag, clear
        for (int i = 1; i <= 4; i++) s_wr(8'(i));
        s_wr(8'h99);
        check("ovf_count", 32'(bus_s.count), 4);
        check("ovf_set", 32'(bus_s.overflow), 1);
        tick();
        check("ovf_sticky", 32'(bus_s.overflow), 1);
        s_clr();
        check("ovf_clr", 32'(bus_s.overflow), 0);
        for (int i = 1; i <= 4; i++) begin
            s_rd();
            check("ovf_drain", 32'(bus_s.dat_o), 32'(i));
        end

        // Underflow: rejected read leaves dat_o untouched
        s_rd();
        check("unf_set", 32'(bus_s.underflow), 1);
        check("unf_dat", 32'(bus_s.dat_o), 32'h04);
        check("unf_count", 32'(bus_s.count), 0);
        // set wins over a simultaneous clear
        bus_s.ren = 1'b1; bus_s.clr_err = 1'b1;
        tick();
        bus_s.ren = 1'b0; bus_s.clr_err = 1'b0;
        check("unf_set_wins", 32'(bus_s.underflow), 1);
        s_clr();
        check("unf_clr", 32'(bus_s.underflow), 0);

        // Full with wen && ren: read only
        for (int i = 0; i < 4; i++) s_wr(8'(8'h10 + i));
        s_both(8'h55);
        check("fullrw_dat", 32'(bus_s.dat_o), 32'h10);
        check("fullrw_count", 32'(bus_s.count), 3);
        check("fullrw_ovf", 32'(bus_s.overflow), 1);
        for (int i = 1; i < 4; i++) begin
            s_rd();
            check("fullrw_drain", 32'(bus_s.dat_o), 32'(8'h10 + i));
        end
        s_clr();

        // count=2 with wen && ren: count holds, order kept
        s_wr(8'h21);
        s_wr(8'h22);
        s_both(8'h23);
        check("mid_rw_dat", 32'(bus_s.dat_o), 32'h21);
        check("mid_rw_count", 32'(bus_s.count), 2);
        s_rd(); check("mid_rw_d2", 32'(bus_s.dat_o), 32'h22);
        s_rd(); check("mid_rw_d3", 32'(bus_s.dat_o), 32'h23);

        // Empty with wen && ren: write only, no bypass
        s_both(8'h31);
        check("emp_rw_count", 32'(bus_s.count), 1);
        check("emp_rw_unf", 32'(bus_s.underflow), 1);
        check("emp_rw_dat", 32'(bus_s.dat_o), 32'h23);
        s_rd(); check("emp_rw_rd", 32'(bus_s.dat_o), 32'h31);
        s_clr();

        // Pointer wrap
        for (int i = 0; i < 10; i++) begin
            s_wr(8'(8'h40 + i));
            s_rd();
            check("wrap_dat", 32'(bus_s.dat_o), 32'(8'h40 + i));
        end
        check("wrap_empty", 32'(bus_s.empty), 1);

        // Mid-operation reset
        s_wr(8'h61); s_wr(8'h62); s_wr(8'h63);
        check("mrst_pre", 32'(bus_s.count), 3);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("mrst_count", 32'(bus_s.count), 0);
        check("mrst_empty", 32'(bus_s.empty), 1);
        check("mrst_dat", 32'(bus_s.dat_o), 0);
        s_wr(8'h71);
        s_rd();
        check("mrst_new", 32'(bus_s.dat_o), 32'h71);
        s_rd();
        check("mrst_unf", 32'(bus_s.underflow), 1);
        check("mrst_hold", 32'(bus_s.dat_o), 32'h71);

        // FWFT instance (also reset by the pulse above)
        check("fw_rst_empty", 32'(bus_f.empty), 1);
        bus_f.dat_i = 8'hA5; bus_f.wen = 1'b1;
        tick();
        bus_f.wen = 1'b0;
        check("fw_empty", 32'(bus_f.empty), 0);
        check("fw_dat", 32'(bus_f.dat_o), 32'hA5);
        check("fw_count1", 32'(bus_f.count), 1);
        bus_f.ren = 1'b1;
        tick();
        bus_f.ren = 1'b0;
        check("fw_pop_count", 32'(bus_f.count), 0);
        check("fw_pop_empty", 32'(bus_f.empty), 1);
        bus_f.wen = 1'b1;
        bus_f.dat_i = 8'hB1; tick();
        bus_f.dat_i = 8'hB2; tick();
        bus_f.wen = 1'b0;
        check("fw_head1", 32'(bus_f.dat_o), 32'hB1);
        check("fw_count2", 32'(bus_f.count), 2);
        bus_f.ren = 1'b1;
        tick();
        bus_f.ren = 1'b0;
        check("fw_head2", 32'(bus_f.dat_o), 32'hB2);
        check("fw_unf", 32'(bus_f.underflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock successor to the team's dual-clock `fifo` block.
- Adds two selectable read modes: standard (registered output) and first-word-fall-through (FWFT).
- Adds an occupancy count and programmable almost-full / almost-empty thresholds.
- Adds sticky overflow / underflow error flags.
- Sits between a producer and a consumer in the same clock domain. Used wherever the CDC FIFO is overkill.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries. Power of 2, >=2.
- FWFT, 0, read mode: 0 = standard (registered output), 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_ni  in  1  synchronous active-low reset
- dat_i  in  WIDTH  write data
- wen  in  1  write request
- ren  in  1  read request
- clr_err  in  1  clears the overflow/underflow sticky flags
- dat_o  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst_ni low at a clk edge) takes priority over everything:
  - read/write pointers = 0, count = 0;
  - empty = 1, full = 0, almost_empty = 1;
  - almost_full = 0;
  - overflow = 0, underflow = 0;
  - dat_o = 0 in standard mode.
- Memory contents are not reset. A mid-operation reset discards all stored words.
- Pointers are AW+1 bits (AW = log2 DEPTH) and wrap naturally modulo 2*DEPTH. Memory index is ptr[AW-1:0].
- count = wptr - rptr, modulo 2^(AW+1).
- All flags are registered, or decoded purely from registered count. No combinational path from wen/ren to any flag.
- Write accept: wen && !full. The word is stored at mem[wptr] and wptr increments.
- Read accept: ren && !empty. rptr increments.
- Simultaneous accepted write and read: count unchanged.
- Full with wen && ren: only the read is accepted. The write is rejected, overflow sets, count becomes DEPTH-1.
- Empty with wen && ren: only the write is accepted. The read is rejected, underflow sets, count becomes 1. There is no bypass.
- Standard mode (FWFT=0): on an accepted read, dat_o <= mem[rptr] at the same edge, so data is valid one cycle after ren. dat_o holds its value otherwise.
- FWFT mode (FWFT=1):
  - dat_o = mem[rptr[AW-1:0]] combinationally. It is valid whenever empty = 0.
  - ren acknowledges/pops the head word.
  - A write into an empty FIFO appears on dat_o, with empty = 0, the cycle after the write edge.
- Error flags:
  - overflow sets on a rejected write; underflow sets on a rejected read.
  - Both clear on clr_err.
  - If set and clear happen in the same cycle, set wins.
- Flag updates: full/empty/almost_* reflect the new count in the cycle after the edge that changed it.

Decomposition:
- Shared header fifo_pkg:
  - clog2 constant function;
  - FWFT_OFF/FWFT_ON mode constants;
  - parameter-legality checks (simulation $error for a non-power-of-2 DEPTH or out-of-range thresholds).
- Sub-module fifo_mem:
  - DEPTH x WIDTH storage;
  - synchronous write, asynchronous read, no reset;
  - reusable by the dual-clock fifo.
- Top: pointers, count, flags, mode mux.

Test Plan:
- Reset with WIDTH=8, DEPTH=4, FWFT=0: hold rst_ni=0 for 2 edges, release -> count=0, empty=1, full=0, almost_empty=1, overflow=underflow=0, dat_o=0.
- Fill then drain:
  - write 0x11,0x22,0x33,0x44 -> count goes 1,2,3,4 and full=1 after the 4th write; almost_full=1 once count>=2 (AF_THRESH=2).
  - Then read 4x -> dat_o 0x11,0x22,0x33,0x44, each one cycle after its ren; empty=1 at the end.
- Overflow/underflow:
  - fifo full, wen=1 -> data dropped, count stays 4, overflow=1 and stays 1.
  - Pulse clr_err -> 0.
  - Empty fifo, ren=1 -> underflow=1, dat_o unchanged.
- Simultaneous ops:
  - full with wen=ren=1 -> head read out, write rejected, count=3, overflow=1.
  - count=2 with wen=ren=1 -> count stays 2, order preserved.
- FWFT=1:
  - write 0xA5 into an empty fifo -> next cycle empty=0 and dat_o=0xA5 with no ren.
  - ren=1 -> count=0, empty=1 the next cycle.
- Wrap and reset mid-operation:
  - 10 write/read pairs with DEPTH=4 -> data order intact across the pointer wrap.
  - rst_ni=0 with count=3 -> count=0, empty=1; a subsequent read returns only newly written data.
